bus_decoder_1x2: RTL and testbench
==================================

Name: bus_decoder_1x2

Overview:
- Single-master to two-slave bus decoder: the responder-side counterpart of the 2-to-1 arbiter.
- Sits downstream of the arbiter. It takes the one arbitrated master request, decodes the address to slave 0 or slave 1, and forwards a registered copy of the request.
- Returns the selected slave's ack and read data to the master.
- Unmapped addresses and non-responding slaves complete with an error ack, so the master never hangs.

Parameters:
- S0_BASE, 32'h0000_0000, slave 0 match value; hit when (i_addr & S0_MASK) == S0_BASE
- S0_MASK, 32'hC000_0000, slave 0 decode mask
- S1_BASE, 32'h8000_0000, slave 1 match value
- S1_MASK, 32'hC000_0000, slave 1 decode mask
- TIMEOUT, 8'd255, slave-enable cycles without ack before error completion (legal 1..255)

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_bus_en  in  1  master request; held until the master sees o_ack
- i_wr_en  in  1  1=write, 0=read
- i_wr_data  in  32  master write data
- i_addr  in  32  master address
- i_byte_en  in  4  byte enables
- i_atomic  in  1  atomic qualifier
- i_id  in  1  requester id from arbiter
- o_ack  out  1  one-cycle completion pulse to master
- o_err  out  1  valid with o_ack; 1=unmapped or timeout
- o_rd_data  out  32  read data, valid with o_ack
- o_bus_en0/o_bus_en1  out  1  slave request
- o_wr_en0/o_wr_en1  out  1  slave write enable
- o_wr_data0/o_wr_data1  out  32  slave write data
- o_addr0/o_addr1  out  32  slave address (full, unmodified)
- o_byte_en0/o_byte_en1  out  4  slave byte enables
- o_atomic0/o_atomic1  out  1  slave atomic
- o_id0/o_id1  out  1  slave requester id
- i_ack0/i_ack1  in  1  slave completion
- i_rd_data0/i_rd_data1  in  32  slave read data, valid with i_ackN

Behaviour:
- All outputs are registered. On reset: every output is 0, state is IDLE, timeout counter is 0.
- FSM states:
  - IDLE: if i_bus_en=1, decode. S0 hit -> S0; else S1 hit -> S1; else -> RESP with err=1, rd_data=0. Slave 0 wins if both decode. i_bus_en=0 -> stay in IDLE.
  - S0/S1: entering loads o_bus_enN=1 and copies wr_en/wr_data/addr/byte_en/atomic/id from the master inputs sampled on the IDLE cycle. These copies stay stable for the whole transaction.
    - i_ackN=1 -> RESP with err=0, rd_data=i_rd_dataN, counter cleared.
    - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no ack -> RESP with err=1, rd_data=0.
    - Leaving S0/S1 clears all of that slave's outputs to 0 on the same edge.
  - RESP: o_ack=1 for exactly one cycle; o_err and o_rd_data are valid in that cycle. Next state is IDLE unconditionally. i_bus_en is ignored during RESP; the master drops it the cycle after seeing o_ack.
- Latency:
  - Request seen in IDLE at cycle 0 -> o_bus_enN=1 in cycle 1.
  - Slave ack in cycle k -> o_ack=1 and o_bus_enN=0 in cycle k+1; IDLE in cycle k+2.
  - Unmapped address: o_ack=1 and o_err=1 in cycle 1.
  - Timeout: o_ack=1 and o_err=1 in cycle TIMEOUT+1.
- o_ack, o_err and o_rd_data are 0 in every cycle except RESP.
- Boundary rules:
  - An ack from the non-selected slave, or any slave ack in IDLE or RESP, is ignored.
  - Ack and timeout in the same cycle: ack wins, err=0.
  - Only one transaction is in flight; no new request is decoded until RESP completes.
  - Master inputs changing while in S0/S1 have no effect on the slave outputs.
  - Reset mid-transaction: next edge sets all outputs to 0 and state to IDLE; no ack is issued for the aborted transaction.
  - TIMEOUT=1: timeout fires if there is no ack in the first enabled cycle.
- Slave outputs for the unselected slave stay 0 throughout.

Test Plan:
- Read S0: i_addr=32'h0000_0010, i_wr_en=0; i_ack0=1 with i_rd_data0=32'hDEADBEEF in cycle 3 -> o_bus_en0=1 in cycles 1-3; o_ack=1, o_rd_data=32'hDEADBEEF, o_err=0 in cycle 4; o_bus_en1=0 throughout.
- Write S1: i_addr=32'h8000_0004, i_wr_data=32'h1234_5678, i_byte_en=4'b0011, i_id=1 -> o_addr1=32'h8000_0004, o_wr_data1=32'h1234_5678, o_byte_en1=4'b0011, o_id1=1 from cycle 1; i_ack1 in cycle 1 -> o_ack in cycle 2.
- Unmapped: i_addr=32'h4000_0000 (and 32'hC000_0000) -> no slave enable; o_ack=1, o_err=1, o_rd_data=0 in cycle 1.
- Timeout with TIMEOUT=4: request to S0, slave 0 never acks -> o_bus_en0=1 in cycles 1-4; o_ack=1, o_err=1 in cycle 5. Repeat with i_ack0 pulsed in cycle 4 -> o_err=0.
- Stray ack: S0 transaction active, i_ack1=1 with i_rd_data1=32'hFFFF_FFFF in cycle 2 -> no o_ack; later i_ack0 completes normally with slave 0 data.
- Reset mid-transaction: assert i_rst in cycle 2 of an S1 access -> all outputs 0 from the next cycle, no o_ack pulse; a new S0 request after reset completes normally.

Source files
------------

// File: rtl/bus_decoder_1x2.sv
// Single-master to two-slave bus decoder: routes one arbitrated request to the
// slave whose address window matches and returns that slave's ack/read data.
module bus_decoder_1x2 #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hC000_0000,
    parameter logic [31:0] S1_BASE = 32'h8000_0000,
    parameter logic [31:0] S1_MASK = 32'hC000_0000,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_byte_en,
    input  logic        i_atomic,
    input  logic        i_id,
    output logic        o_ack,
    output logic        o_err,
    output logic [31:0] o_rd_data,
    output logic        o_bus_en0,
    output logic        o_wr_en0,
    output logic [31:0] o_wr_data0,
    output logic [31:0] o_addr0,
    output logic [3:0]  o_byte_en0,
    output logic        o_atomic0,
    output logic        o_id0,
    input  logic        i_ack0,
    input  logic [31:0] i_rd_data0,
    output logic        o_bus_en1,
    output logic        o_wr_en1,
    output logic [31:0] o_wr_data1,
    output logic [31:0] o_addr1,
    output logic [3:0]  o_byte_en1,
    output logic        o_atomic1,
    output logic        o_id1,
    input  logic        i_ack1,
    input  logic [31:0] i_rd_data1
);

    typedef enum logic [1:0] {IDLE, SEL0, SEL1, RESP} state_t;

    typedef struct packed {
        logic        wr_en;
        logic [31:0] wr_data;
        logic [31:0] addr;
        logic [3:0]  byte_en;
        logic        atomic;
        logic        id;
    } req_t;

    state_t      state, state_next;
    req_t        req_in, req0_q, req0_d, req1_q, req1_d;
    logic        en0_q, en0_d, en1_q, en1_d;
    logic        ack_q, ack_d, err_q, err_d;
    logic [31:0] rd_q, rd_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        hit0, hit1, expired;

    assign req_in = '{wr_en: i_wr_en, wr_data: i_wr_data, addr: i_addr,
                      byte_en: i_byte_en, atomic: i_atomic, id: i_id};

    assign hit0    = (i_addr & S0_MASK) == S0_BASE;
    assign hit1    = (i_addr & S1_MASK) == S1_BASE;
    // Last enabled cycle a slave gets before the request is failed.
    assign expired = (cnt_q == TIMEOUT - 8'd1);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves a latch.
        state_next = state;
        case (state)
            IDLE: if (i_bus_en) begin
                if (hit0)      state_next = SEL0;
                else if (hit1) state_next = SEL1;
                else           state_next = RESP;
            end
            SEL0:    if (i_ack0 || expired) state_next = RESP;
            SEL1:    if (i_ack1 || expired) state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        en0_d  = 1'b0;
        en1_d  = 1'b0;
        req0_d = '0;
        req1_d = '0;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        rd_d   = '0;
        cnt_d  = '0;
        case (state)
            IDLE: begin
                if (state_next == SEL0) begin
                    en0_d  = 1'b1;
                    req0_d = req_in;
                end else if (state_next == SEL1) begin
                    en1_d  = 1'b1;
                    req1_d = req_in;
                end else if (state_next == RESP) begin
                    ack_d = 1'b1;
                    err_d = 1'b1;
                end
            end
            SEL0: begin
                if (state_next == SEL0) begin
                    en0_d  = 1'b1;
                    req0_d = req0_q;
                    cnt_d  = cnt_q + 8'd1;
                end else begin
                    ack_d = 1'b1;
                    err_d = ~i_ack0;
                    rd_d  = i_ack0 ? i_rd_data0 : '0;
                end
            end
            SEL1: begin
                if (state_next == SEL1) begin
                    en1_d  = 1'b1;
                    req1_d = req1_q;
                    cnt_d  = cnt_q + 8'd1;
                end else begin
                    ack_d = 1'b1;
                    err_d = ~i_ack1;
                    rd_d  = i_ack1 ? i_rd_data1 : '0;
                end
            end
            default: ;
        endcase
    end

    // NOTE: every output register is reset so an aborted access leaves nothing behind.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            en0_q  <= 1'b0;
            en1_q  <= 1'b0;
            req0_q <= '0;
            req1_q <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rd_q   <= '0;
            cnt_q  <= '0;
        end else begin
            en0_q  <= en0_d;
            en1_q  <= en1_d;
            req0_q <= req0_d;
            req1_q <= req1_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_err      = err_q;
    assign o_rd_data  = rd_q;
    assign o_bus_en0  = en0_q;
    assign o_wr_en0   = req0_q.wr_en;
    assign o_wr_data0 = req0_q.wr_data;
    assign o_addr0    = req0_q.addr;
    assign o_byte_en0 = req0_q.byte_en;
    assign o_atomic0  = req0_q.atomic;
    assign o_id0      = req0_q.id;
    assign o_bus_en1  = en1_q;
    assign o_wr_en1   = req1_q.wr_en;
    assign o_wr_data1 = req1_q.wr_data;
    assign o_addr1    = req1_q.addr;
    assign o_byte_en1 = req1_q.byte_en;
    assign o_atomic1  = req1_q.atomic;
    assign o_id1      = req1_q.id;

endmodule

// File: tb/tb_bus_decoder_1x2.sv
// Bench for bus_decoder_1x2: scoreboard of expected completions plus
// cycle-by-cycle checks of slave enables and forwarded request fields.
module tb_bus_decoder_1x2;

    logic        clk = 1'b0;
    logic        i_rst, i_bus_en, i_wr_en, i_atomic, i_id;
    logic [31:0] i_wr_data, i_addr;
    logic [3:0]  i_byte_en;
    logic        i_ack0, i_ack1;
    logic [31:0] i_rd_data0, i_rd_data1;
    logic        bus_en_t1;

    logic        o_ack, o_err, o_bus_en0, o_wr_en0, o_atomic0, o_id0;
    logic        o_bus_en1, o_wr_en1, o_atomic1, o_id1;
    logic [31:0] o_rd_data, o_wr_data0, o_addr0, o_wr_data1, o_addr1;
    logic [3:0]  o_byte_en0, o_byte_en1;

    logic        t1_ack, t1_err, t1_bus_en0, t1_wr_en0, t1_atomic0, t1_id0;
    logic        t1_bus_en1, t1_wr_en1, t1_atomic1, t1_id1;
    logic [31:0] t1_rd_data, t1_wr_data0, t1_addr0, t1_wr_data1, t1_addr1;
    logic [3:0]  t1_byte_en0, t1_byte_en1;

    always #5 clk = ~clk;

    bus_decoder_1x2 #(.TIMEOUT(8'd4)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_bus_en(i_bus_en), .i_wr_en(i_wr_en),
        .i_wr_data(i_wr_data), .i_addr(i_addr), .i_byte_en(i_byte_en),
        .i_atomic(i_atomic), .i_id(i_id),
        .o_ack(o_ack), .o_err(o_err), .o_rd_data(o_rd_data),
        .o_bus_en0(o_bus_en0), .o_wr_en0(o_wr_en0), .o_wr_data0(o_wr_data0),
        .o_addr0(o_addr0), .o_byte_en0(o_byte_en0), .o_atomic0(o_atomic0), .o_id0(o_id0),
        .i_ack0(i_ack0), .i_rd_data0(i_rd_data0),
        .o_bus_en1(o_bus_en1), .o_wr_en1(o_wr_en1), .o_wr_data1(o_wr_data1),
        .o_addr1(o_addr1), .o_byte_en1(o_byte_en1), .o_atomic1(o_atomic1), .o_id1(o_id1),
        .i_ack1(i_ack1), .i_rd_data1(i_rd_data1)
    );

    // Second instance with the shortest legal timeout, fed its own request line.
    bus_decoder_1x2 #(.TIMEOUT(8'd1)) dut_t1 (
        .i_clk(clk), .i_rst(i_rst), .i_bus_en(bus_en_t1), .i_wr_en(i_wr_en),
        .i_wr_data(i_wr_data), .i_addr(i_addr), .i_byte_en(i_byte_en),
        .i_atomic(i_atomic), .i_id(i_id),
        .o_ack(t1_ack), .o_err(t1_err), .o_rd_data(t1_rd_data),
        .o_bus_en0(t1_bus_en0), .o_wr_en0(t1_wr_en0), .o_wr_data0(t1_wr_data0),
        .o_addr0(t1_addr0), .o_byte_en0(t1_byte_en0), .o_atomic0(t1_atomic0), .o_id0(t1_id0),
        .i_ack0(1'b0), .i_rd_data0(32'h0),
        .o_bus_en1(t1_bus_en1), .o_wr_en1(t1_wr_en1), .o_wr_data1(t1_wr_data1),
        .o_addr1(t1_addr1), .o_byte_en1(t1_byte_en1), .o_atomic1(t1_atomic1), .o_id1(t1_id1),
        .i_ack1(1'b0), .i_rd_data1(32'h0)
    );

    typedef struct {
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic        mon_on = 1'b0;
    logic [255:0] all_out;

    assign all_out = 256'({o_ack, o_err, o_rd_data,
                           o_bus_en0, o_wr_en0, o_wr_data0, o_addr0, o_byte_en0, o_atomic0, o_id0,
                           o_bus_en1, o_wr_en1, o_wr_data1, o_addr1, o_byte_en1, o_atomic1, o_id1});

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Completion monitor: every o_ack must match the oldest expected result.
    always @(negedge clk) begin
        if (mon_on) begin
            if (o_ack === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 256'(o_ack), 256'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_err", 256'(o_err), 256'(e.err));
                    check("resp_rd_data", 256'(o_rd_data), 256'(e.rd));
                end
            end else begin
                check("quiet_resp", 256'({o_ack, o_err, o_rd_data}), 256'd0);
            end
            check("one_slave", 256'(o_bus_en0 & o_bus_en1), 256'd0);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; sel is 0/1 for a slave or -1 for unmapped.
    // ack_cyc / stray_cyc of -1 mean no such pulse. Master inputs other than
    // i_bus_en are scrambled after cycle 0 to show they are not re-sampled.
    task automatic txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic atomic, input logic id,
                       input int sel, input int ack_cyc, input logic [31:0] ack_data,
                       input int stray_cyc, input int done_cyc, input logic exp_err);
        exp_t e;
        e.err = exp_err;
        e.rd  = exp_err ? 32'h0 : ack_data;
        sb.push_back(e);
        for (int c = 0; c <= done_cyc + 1; c++) begin
            i_ack0     = 1'b0;
            i_ack1     = 1'b0;
            i_rd_data0 = $urandom;
            i_rd_data1 = $urandom;
            if (c == 0) begin
                i_bus_en  = 1'b1;
                i_addr    = addr;
                i_wr_en   = wr;
                i_wr_data = wdata;
                i_byte_en = be;
                i_atomic  = atomic;
                i_id      = id;
            end else begin
                i_addr    = $urandom;
                i_wr_en   = 1'($urandom);
                i_wr_data = $urandom;
                i_byte_en = 4'($urandom);
                i_atomic  = 1'($urandom);
                i_id      = 1'($urandom);
            end
            if (c == ack_cyc) begin
                if (sel == 0) begin i_ack0 = 1'b1; i_rd_data0 = ack_data; end
                else          begin i_ack1 = 1'b1; i_rd_data1 = ack_data; end
            end
            if (c == stray_cyc) begin
                if (sel == 0) begin i_ack1 = 1'b1; i_rd_data1 = 32'hFFFF_FFFF; end
                else          begin i_ack0 = 1'b1; i_rd_data0 = 32'hFFFF_FFFF; end
            end
            if (c == done_cyc + 1) i_bus_en = 1'b0;
            @(negedge clk);
            check("ack_timing", 256'(o_ack), 256'(c == done_cyc));
            check("bus_en0", 256'(o_bus_en0), 256'(sel == 0 && c >= 1 && c < done_cyc));
            check("bus_en1", 256'(o_bus_en1), 256'(sel == 1 && c >= 1 && c < done_cyc));
            if (sel == 0 && c >= 1 && c < done_cyc) begin
                check("req0_fields",
                      256'({o_wr_en0, o_wr_data0, o_addr0, o_byte_en0, o_atomic0, o_id0}),
                      256'({wr, wdata, addr, be, atomic, id}));
                check("req1_idle",
                      256'({o_wr_en1, o_wr_data1, o_addr1, o_byte_en1, o_atomic1, o_id1}), 256'd0);
            end
            if (sel == 1 && c >= 1 && c < done_cyc) begin
                check("req1_fields",
                      256'({o_wr_en1, o_wr_data1, o_addr1, o_byte_en1, o_atomic1, o_id1}),
                      256'({wr, wdata, addr, be, atomic, id}));
                check("req0_idle",
                      256'({o_wr_en0, o_wr_data0, o_addr0, o_byte_en0, o_atomic0, o_id0}), 256'd0);
            end
            if (c == done_cyc)
                check("slaves_cleared", 256'({o_bus_en0, o_addr0, o_bus_en1, o_addr1}), 256'd0);
            next_cycle();
        end
        i_ack0 = 1'b0;
        i_ack1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1; i_bus_en = 1'b0; bus_en_t1 = 1'b0; i_wr_en = 1'b0;
        i_wr_data = '0; i_addr = '0; i_byte_en = '0; i_atomic = 1'b0; i_id = 1'b0;
        i_ack0 = 1'b0; i_ack1 = 1'b0; i_rd_data0 = '0; i_rd_data1 = '0;
        repeat (3) next_cycle();
        @(negedge clk);
        check("reset_outputs", all_out, 256'd0);
        check("reset_t1", 256'({t1_ack, t1_err, t1_bus_en0, t1_bus_en1}), 256'd0);
        next_cycle();
        i_rst  = 1'b0;
        mon_on = 1'b1;
        next_cycle();

        // Read from slave 0, ack in cycle 3.
        txn(32'h0000_0010, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, 0, 3, 32'hDEAD_BEEF, -1, 4, 1'b0);
        // Write to slave 1, ack in cycle 1.
        txn(32'h8000_0004, 1'b1, 32'h1234_5678, 4'b0011, 1'b1, 1'b1, 1, 1, 32'h0, -1, 2, 1'b0);
        // Unmapped windows.
        txn(32'h4000_0000, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, -1, -1, 32'h0, -1, 1, 1'b1);
        txn(32'hC000_0000, 1'b1, 32'hA5A5_A5A5, 4'h1, 1'b0, 1'b1, -1, -1, 32'h0, -1, 1, 1'b1);
        // Timeout (TIMEOUT=4), then ack landing on the final enabled cycle.
        txn(32'h0000_0100, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, 0, -1, 32'h0, -1, 5, 1'b1);
        txn(32'h0000_0104, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 0, 4, 32'hCAFE_0004, -1, 5, 1'b0);
        // Timeout on slave 1 as well.
        txn(32'hBFFF_FFFC, 1'b1, 32'h5555_AAAA, 4'b1000, 1'b1, 1'b0, 1, -1, 32'h0, -1, 5, 1'b1);
        // Stray ack from slave 1 while slave 0 is selected.
        txn(32'h3FFF_0000, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, 0, 3, 32'h0BAD_F00D, 2, 4, 1'b0);
        // Stray ack from slave 0 while slave 1 is selected.
        txn(32'h8000_0ABC, 1'b0, 32'h0, 4'h3, 1'b0, 1'b1, 1, 2, 32'h1357_9BDF, 1, 3, 1'b0);

        // Reset in cycle 2 of a slave 1 access: no ack, everything cleared.
        i_bus_en = 1'b1; i_addr = 32'h8000_0040; i_wr_en = 1'b1;
        i_wr_data = 32'h7777_0000; i_byte_en = 4'hF; i_atomic = 1'b0; i_id = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rst_mid_en1", 256'(o_bus_en1), 256'd1);
        next_cycle();
        i_rst = 1'b1;
        next_cycle();
        i_rst    = 1'b0;
        i_bus_en = 1'b0;
        @(negedge clk);
        check("rst_mid_cleared", all_out, 256'd0);
        next_cycle();
        @(negedge clk);
        check("rst_mid_no_ack", all_out, 256'd0);
        next_cycle();
        txn(32'h0000_0020, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, 0, 2, 32'h600D_DA7A, -1, 3, 1'b0);

        // TIMEOUT=1 instance: no ack in the first enabled cycle fails the access.
        i_addr = 32'h0000_0010; i_wr_en = 1'b0; bus_en_t1 = 1'b1;
        @(negedge clk);
        check("t1_c0", 256'({t1_ack, t1_bus_en0}), 256'd0);
        next_cycle();
        @(negedge clk);
        check("t1_c1", 256'({t1_ack, t1_err, t1_bus_en0}), 256'(3'b001));
        next_cycle();
        bus_en_t1 = 1'b0;
        @(negedge clk);
        check("t1_c2", 256'({t1_ack, t1_err, t1_bus_en0, t1_rd_data}), 256'({3'b110, 32'h0}));
        next_cycle();
        @(negedge clk);
        check("t1_c3", 256'({t1_ack, t1_err, t1_bus_en0}), 256'd0);
        next_cycle();

        repeat (2) next_cycle();
        check("scoreboard_drained", 256'(sb.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
